lsu_mem_ctrl: RTL and testbench

- Load/store sequencer between the single-cycle core's decode/execute stage and a req/ack data-memory bus.
- Takes the decoded memory request (memReq, memWrite, funct3) plus the ALU-computed address and store data.
- Issues one bus transaction, stalls the core until it completes, and returns load data extracted and sign/zero-extended.
- Detects misaligned accesses without touching the bus.

---
 rtl/lsu_mem_ctrl.sv | 166 ++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer: one req/ack bus transaction per core memory access, core stalled meanwhile.
// Optional ack timeout is compiled in when LSU_MEM_TIMEOUT_EN is defined.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_memReq,
  input  logic        i_memWrite,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdataValid,
  output logic        o_misaligned,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_byteEn,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  state_e      state_q;
  logic        bus_req_q, bus_we_q, rdata_valid_q;
  logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]  bus_be_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        misaligned, accept, mis_pulse;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_ext, rdata_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Request decode: lane enables, replicated store data and alignment check.
  always_comb begin
    misaligned = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << i_addr[1:0];
        wdata_d = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        be_d       = 4'b0011 << {i_addr[1], 1'b0};
        wdata_d    = {2{i_wdata[15:0]}};
        misaligned = i_addr[0];
      end
      default: misaligned = |i_addr[1:0];
    endcase
  end

  assign accept    = (state_q == StIdle) && i_memReq && !misaligned;
  assign mis_pulse = (state_q == StIdle) && i_memReq && misaligned;

  // Load extraction uses the offset and size captured at accept time.
  always_comb begin
    rdata_shift = i_bus_rdata >> {off_q, 3'b000};
    byte_sel    = rdata_shift[7:0];
    half_sel    = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{byte_sel[7] & ~funct3_q[2]}}, byte_sel};
      2'b01:   load_ext = {{16{half_sel[15] & ~funct3_q[2]}}, half_sel};
      default: load_ext = i_bus_rdata;
    endcase
  end

`ifdef LSU_MEM_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            expired;
  assign expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StIdle;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      bus_be_q      <= '0;
      funct3_q      <= '0;
      off_q         <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
`ifdef LSU_MEM_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      rdata_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q     <= StReq;
            bus_req_q   <= 1'b1;
            bus_we_q    <= i_memWrite;
            bus_addr_q  <= {i_addr[31:2], 2'b00};
            bus_wdata_q <= wdata_d;
            bus_be_q    <= be_d;
            funct3_q    <= i_funct3;
            off_q       <= i_addr[1:0];
`ifdef LSU_MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        StReq: begin
          if (i_bus_ack) begin
            state_q   <= StDone;
            bus_req_q <= 1'b0;
            if (!bus_we_q) begin
              rdata_q       <= load_ext;
              rdata_valid_q <= 1'b1;
            end
          end
`ifdef LSU_MEM_TIMEOUT_EN
          else if (expired) begin
            state_q   <= StDone;
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        StDone: begin
          // The request still present here belongs to the instruction just finished.
          state_q <= StIdle;
`ifdef LSU_MEM_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_stall      = accept || (state_q == StReq);
  assign o_rdata      = rdata_q;
  assign o_rdataValid = rdata_valid_q;
`ifdef LSU_MEM_TIMEOUT_EN
  assign o_misaligned = mis_pulse || timeout_q;
`else
  assign o_misaligned = mis_pulse;
`endif
  assign o_bus_req    = bus_req_q;
  assign o_bus_we     = bus_we_q;
  assign o_bus_addr   = bus_addr_q;
  assign o_bus_wdata  = bus_wdata_q;
  assign o_bus_byteEn = bus_be_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl; inputs driven #1 after posedge, sampled at negedge.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_write, ack;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, brdata;
  logic        o_stall, o_rdataValid, o_misaligned, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_byteEn;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_load;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_memReq     (mem_req),
    .i_memWrite   (mem_write),
    .i_funct3     (f3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_stall      (o_stall),
    .o_rdata      (o_rdata),
    .o_rdataValid (o_rdataValid),
    .o_misaligned (o_misaligned),
    .o_bus_req    (o_bus_req),
    .o_bus_we     (o_bus_we),
    .o_bus_addr   (o_bus_addr),
    .o_bus_wdata  (o_bus_wdata),
    .o_bus_byteEn (o_bus_byteEn),
    .i_bus_ack    (ack),
    .i_bus_rdata  (brdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_req = 0; mem_write = 0; ack = 0; f3 = 0; addr = 0; wdata = 0; brdata = 0;
    #2;
    checks++;
    if ({o_stall, o_rdata, o_rdataValid, o_misaligned, o_bus_req, o_bus_we, o_bus_addr,
         o_bus_wdata, o_bus_byteEn} !== '0) begin
      failures++; $display("FAIL reset_outputs got stall=%b req=%b rdata=%h exp all zero",
                           o_stall, o_bus_req, o_rdata);
    end
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_stall, o_bus_req, o_rdataValid, o_misaligned} !== 4'b0) begin
      failures++; $display("FAIL reset_release got %b exp 0000",
                           {o_stall, o_bus_req, o_rdataValid, o_misaligned});
    end
  endtask

  task automatic test_lw();
    next_cycle(); mem_req = 1; mem_write = 0; f3 = 3'b010; addr = 32'h100; ack = 0;
    @(negedge clk);
    checks++;
    if ({o_stall, o_bus_req} !== 2'b10) begin
      failures++; $display("FAIL lw_accept stall/req got %b exp 10", {o_stall, o_bus_req});
    end
    next_cycle(); ack = 1; brdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({o_stall, o_bus_req, o_bus_we} !== 3'b110) begin
      failures++; $display("FAIL lw_req stall/req/we got %b exp 110", {o_stall, o_bus_req, o_bus_we});
    end
    checks++;
    if (o_bus_addr !== 32'h100) begin
      failures++; $display("FAIL lw_addr got %h exp 00000100", o_bus_addr);
    end
    checks++;
    if (o_bus_byteEn !== 4'b1111) begin
      failures++; $display("FAIL lw_be got %b exp 1111", o_bus_byteEn);
    end
    next_cycle(); ack = 0;
    @(negedge clk);
    checks++;
    if ({o_stall, o_rdataValid} !== 2'b01) begin
      failures++; $display("FAIL lw_done stall/valid got %b exp 01", {o_stall, o_rdataValid});
    end
    checks++;
    if (o_rdata !== 32'hDEADBEEF) begin
      failures++; $display("FAIL lw_rdata got %h exp deadbeef", o_rdata);
    end
    last_load = 32'hDEADBEEF;
    next_cycle(); mem_req = 0;
    @(negedge clk);
    checks++;
    if ({o_bus_req, o_stall, o_rdataValid} !== 3'b000) begin
      failures++; $display("FAIL lw_after_done req/stall/valid got %b exp 000",
                           {o_bus_req, o_stall, o_rdataValid});
    end
    checks++;
    if (o_rdata !== last_load) begin
      failures++; $display("FAIL lw_rdata_hold got %h exp %h", o_rdata, last_load);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  tf3 [0:4];
    logic [31:0] tad [0:4];
    logic [31:0] trd [0:4];
    logic [3:0]  tbe [0:4];
    logic [31:0] texp [0:4];
    tf3  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    tad  = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101};
    trd  = '{32'h80123456, 32'h80123456, 32'h80010000, 32'h1234F00D, 32'h00007F00};
    tbe  = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010};
    texp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F};
    for (int i = 0; i < 5; i++) begin
      next_cycle(); mem_req = 1; mem_write = 0; f3 = tf3[i]; addr = tad[i]; ack = 0;
      @(negedge clk);
      checks++;
      if (o_stall !== 1'b1) begin
        failures++; $display("FAIL load%0d_stall got %b exp 1", i, o_stall);
      end
      next_cycle(); ack = 1; brdata = trd[i];
      @(negedge clk);
      checks++;
      if (o_bus_byteEn !== tbe[i]) begin
        failures++; $display("FAIL load%0d_be got %b exp %b", i, o_bus_byteEn, tbe[i]);
      end
      checks++;
      if (o_bus_addr !== 32'h100) begin
        failures++; $display("FAIL load%0d_addr got %h exp 00000100", i, o_bus_addr);
      end
      next_cycle(); ack = 0;
      @(negedge clk);
      checks++;
      if ({o_rdataValid, o_rdata} !== {1'b1, texp[i]}) begin
        failures++; $display("FAIL load%0d_rdata got v=%b %h exp v=1 %h", i, o_rdataValid,
                             o_rdata, texp[i]);
      end
      last_load = texp[i];
      next_cycle(); mem_req = 0;
    end
  endtask

  task automatic test_sh_delayed();
    int stalls = 0;
    next_cycle(); mem_req = 1; mem_write = 1; f3 = 3'b001; addr = 32'h202;
    wdata = 32'h1234ABCD; ack = 0;
    @(negedge clk);
    if (o_stall) stalls++;
    for (int k = 1; k <= 5; k++) begin
      next_cycle(); ack = (k == 5);
      @(negedge clk);
      if (o_stall) stalls++;
      checks++;
      if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_byteEn, o_bus_wdata} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hABCDABCD}) begin
        failures++; $display("FAIL sh_wait%0d got req=%b we=%b a=%h be=%b d=%h exp 1 1 200 1100 abcdabcd",
                             k, o_bus_req, o_bus_we, o_bus_addr, o_bus_byteEn, o_bus_wdata);
      end
    end
    next_cycle(); ack = 0;
    @(negedge clk);
    if (o_stall) stalls++;
    checks++;
    if ({o_rdataValid, o_bus_req} !== 2'b00) begin
      failures++; $display("FAIL sh_done valid/req got %b exp 00", {o_rdataValid, o_bus_req});
    end
    checks++;
    if (o_rdata !== last_load) begin
      failures++; $display("FAIL sh_rdata_hold got %h exp %h", o_rdata, last_load);
    end
    checks++;
    if (stalls !== 6) begin
      failures++; $display("FAIL sh_stall_cycles got %0d exp 6", stalls);
    end
    next_cycle(); mem_req = 0; mem_write = 0;
  endtask

  task automatic test_stores();
    logic [2:0]  tf3 [0:1];
    logic [31:0] tad [0:1];
    logic [31:0] twd [0:1];
    logic [3:0]  tbe [0:1];
    logic [31:0] tbw [0:1];
    tf3 = '{3'b000, 3'b010};
    tad = '{32'h201, 32'h204};
    twd = '{32'hCAFE125A, 32'h01234567};
    tbe = '{4'b0010, 4'b1111};
    tbw = '{32'h5A5A5A5A, 32'h01234567};
    for (int i = 0; i < 2; i++) begin
      next_cycle(); mem_req = 1; mem_write = 1; f3 = tf3[i]; addr = tad[i]; wdata = twd[i];
      next_cycle(); ack = 1;
      @(negedge clk);
      checks++;
      if ({o_bus_we, o_bus_byteEn, o_bus_wdata} !== {1'b1, tbe[i], tbw[i]}) begin
        failures++; $display("FAIL store%0d got we=%b be=%b d=%h exp 1 %b %h", i, o_bus_we,
                             o_bus_byteEn, o_bus_wdata, tbe[i], tbw[i]);
      end
      next_cycle(); ack = 0;
      @(negedge clk);
      checks++;
      if ({o_rdataValid, o_rdata} !== {1'b0, last_load}) begin
        failures++; $display("FAIL store%0d_done got v=%b %h exp v=0 %h", i, o_rdataValid,
                             o_rdata, last_load);
      end
      next_cycle(); mem_req = 0; mem_write = 0;
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  tf3 [0:2];
    logic [31:0] tad [0:2];
    tf3 = '{3'b010, 3'b001, 3'b010};
    tad = '{32'h101, 32'h203, 32'h102};
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mem_req = 1; mem_write = (i == 2); f3 = tf3[i]; addr = tad[i];
      @(negedge clk);
      checks++;
      if ({o_misaligned, o_stall, o_bus_req} !== 3'b100) begin
        failures++; $display("FAIL mis%0d_pulse mis/stall/req got %b exp 100", i,
                             {o_misaligned, o_stall, o_bus_req});
      end
      next_cycle(); mem_req = 0; mem_write = 0;
      @(negedge clk);
      checks++;
      if ({o_misaligned, o_bus_req, o_stall} !== 3'b000) begin
        failures++; $display("FAIL mis%0d_after mis/req/stall got %b exp 000", i,
                             {o_misaligned, o_bus_req, o_stall});
      end
    end
  endtask

  task automatic test_ack_idle();
    next_cycle(); ack = 1; brdata = 32'hFFFFFFFF;
    @(negedge clk);
    next_cycle(); ack = 0;
    @(negedge clk);
    checks++;
    if ({o_rdataValid, o_bus_req, o_rdata} !== {2'b00, last_load}) begin
      failures++; $display("FAIL ack_idle got v=%b req=%b %h exp 0 0 %h", o_rdataValid,
                           o_bus_req, o_rdata, last_load);
    end
  endtask

  task automatic test_reset_mid();
    next_cycle(); mem_req = 1; mem_write = 0; f3 = 3'b010; addr = 32'h108; ack = 0;
    next_cycle();
    @(negedge clk);
    checks++;
    if (o_bus_req !== 1'b1) begin
      failures++; $display("FAIL rstmid_inflight req got %b exp 1", o_bus_req);
    end
    #2; mem_req = 0; rst_n = 1'b0;
    #1;
    checks++;
    if ({o_bus_req, o_stall, o_rdata} !== {2'b00, 32'h0}) begin
      failures++; $display("FAIL rstmid_async req/stall got %b rdata %h exp 00 0",
                           {o_bus_req, o_stall}, o_rdata);
    end
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_bus_req, o_stall, o_rdataValid} !== 3'b000) begin
      failures++; $display("FAIL rstmid_idle got %b exp 000", {o_bus_req, o_stall, o_rdataValid});
    end
    next_cycle(); mem_req = 1; addr = 32'h10C;
    next_cycle(); ack = 1; brdata = 32'h0BADF00D;
    @(negedge clk);
    checks++;
    if ({o_bus_req, o_bus_addr} !== {1'b1, 32'h10C}) begin
      failures++; $display("FAIL rstmid_lw_req got req=%b a=%h exp 1 0000010c", o_bus_req,
                           o_bus_addr);
    end
    next_cycle(); ack = 0;
    @(negedge clk);
    checks++;
    if ({o_rdataValid, o_rdata} !== {1'b1, 32'h0BADF00D}) begin
      failures++; $display("FAIL rstmid_lw_data got v=%b %h exp 1 0badf00d", o_rdataValid, o_rdata);
    end
    last_load = 32'h0BADF00D;
    next_cycle(); mem_req = 0;
  endtask

`ifdef LSU_MEM_TIMEOUT_EN
  task automatic test_timeout();
    int reqs = 0;
    next_cycle(); mem_req = 1; mem_write = 0; f3 = 3'b010; addr = 32'h300; ack = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clk);
      if (o_bus_req) reqs++;
    end
    checks++;
    if (reqs !== 4) begin
      failures++; $display("FAIL to_req_cycles got %0d exp 4", reqs);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({o_bus_req, o_misaligned, o_rdataValid, o_stall, o_rdata} !== {4'b0100, 32'h0}) begin
      failures++; $display("FAIL to_expire req/mis/v/stall got %b rdata %h exp 0100 0",
                           {o_bus_req, o_misaligned, o_rdataValid, o_stall}, o_rdata);
    end
    next_cycle(); mem_req = 0;
  endtask
`endif

  initial begin
    last_load = '0;
    test_reset();
    test_lw();
    test_loads();
    test_sh_delayed();
    test_stores();
    test_misaligned();
    test_ack_idle();
    test_reset_mid();
`ifdef LSU_MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
